switch_debouncer_2ch: RTL and testbench

Two-channel input conditioner for the structural gate labs. It takes raw, bouncing board switches, synchronizes them, debounces them, and drives clean `a`/`b` levels into the downstream gate under test (e.g. `or_gate_st`). It also emits one-cycle edge pulses per channel for bench scoreboards and LED/counter logic.

---
 rtl/debounce_pkg.sv | 15 +
 rtl/switch_debouncer_2ch_if.sv | 27 ++
 rtl/debounce_channel.sv | 98 +++++++++
 rtl/switch_debouncer_2ch.sv | 40 ++++
 tb/tb_switch_debouncer_2ch.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/debounce_pkg.sv
// Shared types and defaults for the switch debouncer blocks.
// The state encoding is fixed so bench checkers can decode the debug state.
package debounce_pkg;

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    WAIT_HIGH = 2'd1,
    HIGH      = 2'd2,
    WAIT_LOW  = 2'd3
  } db_state_t;

  localparam int DB_STABLE_CNT_DEF = 50000;
  localparam int DB_CNT_W_DEF      = 16;

endpackage

// File: rtl/switch_debouncer_2ch_if.sv
// Switch-side bundle for the two-channel debouncer: raw inputs, clean levels,
// edge pulses and per-channel debug state. No handshake: all signals are levels or one-cycle pulses.
interface switch_debouncer_2ch_if;
  import debounce_pkg::*;

  logic      sw_a_raw;
  logic      sw_b_raw;
  logic      a;
  logic      b;
  logic      a_rise;
  logic      a_fall;
  logic      b_rise;
  logic      b_fall;
  db_state_t a_state;
  db_state_t b_state;

  modport master (
    output sw_a_raw, sw_b_raw,
    input  a, b, a_rise, a_fall, b_rise, b_fall, a_state, b_state
  );

  modport slave (
    input  sw_a_raw, sw_b_raw,
    output a, b, a_rise, a_fall, b_rise, b_fall, a_state, b_state
  );

endinterface

// File: rtl/debounce_channel.sv
// One debounce channel: 2-flop synchronizer, stability FSM with counter,
// registered level and registered one-cycle rise/fall pulses.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int STABLE_CNT = DB_STABLE_CNT_DEF,
  parameter int CNT_W      = DB_CNT_W_DEF
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      raw,
  output logic      level,
  output logic      rise,
  output logic      fall,
  output db_state_t state
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

  logic             sync1;
  logic             s;
  logic [CNT_W-1:0] cnt;
  db_state_t        state_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             level_nxt;
  logic             rise_nxt;
  logic             fall_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      s     <= 1'b0;
      state <= LOW;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync1 <= raw;
      s     <= sync1;
      state <= state_nxt;
      cnt   <= cnt_nxt;
      level <= level_nxt;
      rise  <= rise_nxt;
      fall  <= fall_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    unique case (state)
      LOW: begin
        if (s) begin
          state_nxt = WAIT_HIGH;
          cnt_nxt   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!s) begin
          state_nxt = LOW;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = HIGH;
          rise_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      HIGH: begin
        if (!s) begin
          state_nxt = WAIT_LOW;
          cnt_nxt   = '0;
        end
      end
      WAIT_LOW: begin
        if (s) begin
          state_nxt = HIGH;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = LOW;
          fall_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = LOW;
        cnt_nxt   = '0;
      end
    endcase
    // Level is registered from the next state so it tracks HIGH/WAIT_LOW exactly.
    level_nxt = (state_nxt == HIGH) || (state_nxt == WAIT_LOW);
  end

endmodule

// File: rtl/switch_debouncer_2ch.sv
// Two independent debounce channels feeding clean a/b levels to a gate under test.
// Wiring only.
module switch_debouncer_2ch
  import debounce_pkg::*;
#(
  parameter int STABLE_CNT = DB_STABLE_CNT_DEF,
  parameter int CNT_W      = DB_CNT_W_DEF
) (
  input logic                  clk,
  input logic                  rst_n,
  switch_debouncer_2ch_if.slave sw
);

  debounce_channel #(
    .STABLE_CNT (STABLE_CNT),
    .CNT_W      (CNT_W)
  ) u_ch_a (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (sw.sw_a_raw),
    .level (sw.a),
    .rise  (sw.a_rise),
    .fall  (sw.a_fall),
    .state (sw.a_state)
  );

  debounce_channel #(
    .STABLE_CNT (STABLE_CNT),
    .CNT_W      (CNT_W)
  ) u_ch_b (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (sw.sw_b_raw),
    .level (sw.b),
    .rise  (sw.b_rise),
    .fall  (sw.b_fall),
    .state (sw.b_state)
  );

endmodule

// File: tb/tb_switch_debouncer_2ch.sv
// Bench for switch_debouncer_2ch: directed scenarios plus random bouncing,
// all cycles compared against a run-length reference model.
module tb_switch_debouncer_2ch;
  import debounce_pkg::*;

  localparam int STABLE_CNT = 4;
  localparam int CNT_W      = 3;
  localparam int W          = 6;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  switch_debouncer_2ch_if sw ();

  switch_debouncer_2ch #(
    .STABLE_CNT (STABLE_CNT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sw    (sw.slave)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // s is the raw input delayed two edges; a new level is accepted once s has
  // disagreed with the current level for STABLE_CNT+1 consecutive edges.
  logic [W-1:0] exp_q[$];
  logic [1:0]   dly [2];
  int           run [2];
  logic         lvl [2];
  logic         m_rise [2];
  logic         m_fall [2];

  always @(posedge clk) begin
    logic raw_now [2];
    logic s_now;
    raw_now[0] = sw.sw_a_raw;
    raw_now[1] = sw.sw_b_raw;
    for (int ch = 0; ch < 2; ch++) begin
      if (!rst_n) begin
        dly[ch] = 2'b00; run[ch] = 0; lvl[ch] = 1'b0;
        m_rise[ch] = 1'b0; m_fall[ch] = 1'b0;
      end else begin
        s_now = dly[ch][1];
        dly[ch] = {dly[ch][0], raw_now[ch]};
        m_rise[ch] = 1'b0;
        m_fall[ch] = 1'b0;
        run[ch] = (s_now != lvl[ch]) ? run[ch] + 1 : 0;
        if (run[ch] == STABLE_CNT + 1) begin
          lvl[ch]    = s_now;
          m_rise[ch] = s_now;
          m_fall[ch] = !s_now;
          run[ch]    = 0;
        end
      end
    end
    exp_q.push_back({lvl[0], lvl[1], m_rise[0], m_fall[0], m_rise[1], m_fall[1]});
  end

  // ---------------- scoreboard / monitor ----------------
  int cnt_a_rise = 0, cnt_a_fall = 0, cnt_b_rise = 0, cnt_b_fall = 0;

  always @(negedge clk) begin
    logic [W-1:0] e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("a",      sw.a,      e[5]);
      check("b",      sw.b,      e[4]);
      check("a_rise", sw.a_rise, e[3]);
      check("a_fall", sw.a_fall, e[2]);
      check("b_rise", sw.b_rise, e[1]);
      check("b_fall", sw.b_fall, e[0]);
    end
    cnt_a_rise += sw.a_rise;
    cnt_a_fall += sw.a_fall;
    cnt_b_rise += sw.b_rise;
    cnt_b_fall += sw.b_fall;
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic clear_counts();
    cnt_a_rise = 0; cnt_a_fall = 0; cnt_b_rise = 0; cnt_b_fall = 0;
  endtask

  task automatic drive(input logic va, input logic vb);
    sw.sw_a_raw = va;
    sw.sw_b_raw = vb;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int hold_a, hold_b;
    rst_n = 1'b0;
    drive(1'b1, 1'b0);

    // 1: switch held high through reset
    tick(3);
    check("rst_a", sw.a, 0);
    check("rst_a_rise", sw.a_rise, 0);
    check("rst_state", sw.a_state, LOW);
    rst_n = 1'b1;
    clear_counts();
    tick(6);
    check("s1_early", sw.a_rise, 0);
    tick(1);
    check("s1_rise", sw.a_rise, 1);
    check("s1_level", sw.a, 1);
    tick(1);
    check("s1_one_cycle", sw.a_rise, 0);

    // 2: clean press
    drive(1'b0, 1'b0);
    tick(12);
    clear_counts();
    drive(1'b1, 1'b0);
    tick(7);
    check("s2_rise", sw.a_rise, 1);
    tick(5);
    check("s2_rise_cnt", cnt_a_rise, 1);
    check("s2_b_quiet", cnt_b_rise + cnt_b_fall, 0);

    // 3: bounce then settle
    drive(1'b0, 1'b0);
    tick(12);
    clear_counts();
    for (int i = 0; i < 4; i++) begin
      drive(~i[0], 1'b0);
      tick(2);
    end
    check("s3_no_rise_bounce", cnt_a_rise, 0);
    drive(1'b1, 1'b0);
    tick(7);
    check("s3_rise", sw.a_rise, 1);
    tick(5);
    check("s3_rise_cnt", cnt_a_rise, 1);

    // 4: short low glitch while high
    clear_counts();
    drive(1'b0, 1'b0);
    tick(3);
    drive(1'b1, 1'b0);
    tick(12);
    check("s4_level", sw.a, 1);
    check("s4_no_fall", cnt_a_fall, 0);

    // 5: simultaneous press and release
    drive(1'b0, 1'b0);
    tick(12);
    drive(1'b1, 1'b1);
    tick(7);
    check("s5_a_rise", sw.a_rise, 1);
    check("s5_b_rise", sw.b_rise, 1);
    tick(3);
    drive(1'b0, 1'b0);
    tick(7);
    check("s5_a_fall", sw.a_fall, 1);
    check("s5_b_fall", sw.b_fall, 1);

    // 6: reset mid-count
    tick(5);
    clear_counts();
    drive(1'b1, 1'b0);
    tick(4);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    check("s6_no_pulse", cnt_a_rise, 0);
    tick(6);
    check("s6_early", sw.a_rise, 0);
    tick(1);
    check("s6_rise", sw.a_rise, 1);
    check("s6_rise_cnt", cnt_a_rise, 1);

    // random bouncing on both channels with occasional resets
    hold_a = 1;
    hold_b = 1;
    for (int c = 0; c < 3000; c++) begin
      if (--hold_a == 0) begin
        sw.sw_a_raw = ~sw.sw_a_raw;
        hold_a = $urandom_range(1, 9);
      end
      if (--hold_b == 0) begin
        sw.sw_b_raw = ~sw.sw_b_raw;
        hold_b = $urandom_range(1, 9);
      end
      rst_n = ($urandom_range(0, 299) != 0);
      tick(1);
    end
    rst_n = 1'b1;
    tick(12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
